// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable thresholds, fill level,
// sticky error flags and a selectable standard / first-word-fall-through read port.
`timescale 1ns/1ps

module fifo_sync_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           full,
    output logic                           almost_full,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_valid,
    output logic                           empty,
    output logic                           almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           overflow,
    output logic                           underflow,
    input  logic                           clr_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status flags decode only the registered level, never same-cycle requests.
    assign full         = (level == LVL_FULL);
    assign empty        = (level == '0);
    assign almost_full  = (level >= LVL_AF);
    assign almost_empty = (level <= LVL_AE);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage is not reset; discarding words only requires clearing the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                level <= level + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                level <= level - 1'b1;
            end
        end
    end

    // Sticky error flags: a new rejected request takes priority over clr_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; zero while empty keeps the port clean after reset.
            assign rd_data  = empty ? '0 : mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_std
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        rd_data <= mem[rd_ptr];
                    end
                end
            end
        end
    endgenerate

endmodule
